// File: rtl/lagd_mem_bank_arb.sv
// Single-bank request arbiter for the LAGD memory subsystem.
// Port 0 is the wide high-priority port. Ports 1..NumReq-1 share the bank
// round-robin. A starvation counter can hand one cycle to the narrow ports.
// Responses come back on the originating port BankAccessLatency cycles after grant.
module lagd_mem_bank_arb #(
    parameter int unsigned NumReq            = 3,
    parameter int unsigned AddrWidth         = 11,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned BankAccessLatency = 1,
    parameter int unsigned WidePriorityWait  = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]                    req_we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   req_strb_i,
    output logic [NumReq-1:0]                    rsp_valid_o,
    output logic [DataWidth-1:0]                 rsp_rdata_o,
    output logic                                 bank_req_o,
    output logic                                 bank_we_o,
    output logic [AddrWidth-1:0]                 bank_addr_o,
    output logic [DataWidth-1:0]                 bank_wdata_o,
    output logic [DataWidth/8-1:0]               bank_be_o,
    input  logic [DataWidth-1:0]                 bank_rdata_i
);

    localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned WaitW   = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
    localparam int unsigned Lat     = BankAccessLatency;

    // One delay-line stage: which port a response in flight belongs to.
    typedef struct packed {
        logic            valid;
        logic [IdxW-1:0] idx;
    } rsp_tag_t;

    localparam logic [WaitW-1:0] WaitMax  = WaitW'(WidePriorityWait);
    localparam logic [IdxW-1:0]  LastPort = IdxW'(NumReq - 1);

    logic [IdxW-1:0]  rr_q, rr_d;
    logic [WaitW-1:0] wait_q, wait_d;
    rsp_tag_t [Lat-1:0] pipe_q, pipe_d;

    logic            narrow_any;
    logic            starve;
    logic            rr_found;
    logic [IdxW-1:0] rr_idx;
    logic [IdxW-1:0] cand;
    int unsigned     cand_sum;
    logic            gnt_narrow;
    logic            gnt_wide;
    logic            gnt_any;
    logic [IdxW-1:0] gnt_idx;

    // Narrow round-robin pick: first valid narrow port at or after rr_q, wrapping to 1.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = IdxW'(1);
        cand_sum = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NumReq - 1; i++) begin
            cand_sum = 32'(rr_q) + i;
            if (cand_sum >= NumReq) begin
                cand_sum = cand_sum - (NumReq - 1);
            end
            cand = IdxW'(cand_sum);
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Winner selection: port 0 by default, narrow winner when port 0 idle or starved out.
    always_comb begin
        narrow_any = |req_valid_i[NumReq-1:1];
        starve     = (WidePriorityWait != 0) && (wait_q == WaitMax);
        gnt_narrow = rr_found && (starve || !req_valid_i[0]);
        gnt_wide   = req_valid_i[0] && !gnt_narrow;
        gnt_any    = gnt_wide || gnt_narrow;
        gnt_idx    = gnt_narrow ? rr_idx : '0;
    end

    // Grant vector and bank mux; everything is zero when nobody is granted.
    always_comb begin
        req_ready_o  = '0;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (gnt_any) begin
            req_ready_o[gnt_idx] = 1'b1;
            bank_req_o           = 1'b1;
            bank_we_o            = req_we_i[gnt_idx];
            bank_addr_o          = req_addr_i[gnt_idx];
            bank_wdata_o         = req_wdata_i[gnt_idx];
            bank_be_o            = req_strb_i[gnt_idx];
        end
    end

    // Pointer and starvation counter next state.
    always_comb begin
        rr_d   = rr_q;
        wait_d = wait_q;
        if (gnt_narrow) begin
            rr_d = (rr_idx == LastPort) ? IdxW'(1) : rr_idx + IdxW'(1);
        end
        if (WidePriorityWait == 0) begin
            wait_d = '0;
        end else if (gnt_narrow || !narrow_any) begin
            wait_d = '0;
        end else if (gnt_wide && (wait_q != WaitMax)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    // Response delay line: stage 0 captures this cycle's grant.
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = gnt_any;
        pipe_d[0].idx   = gnt_idx;
        for (int unsigned s = 1; s < Lat; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    // State registers; reset drops every in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= IdxW'(1);
            wait_q <= '0;
            pipe_q <= '0;
        end else begin
            rr_q   <= rr_d;
            wait_q <= wait_d;
            pipe_q <= pipe_d;
        end
    end

    // Response steering from the last delay stage; data is the bank read port.
    always_comb begin
        rsp_valid_o = '0;
        if (pipe_q[Lat-1].valid) begin
            rsp_valid_o[pipe_q[Lat-1].idx] = 1'b1;
        end
    end

    assign rsp_rdata_o = bank_rdata_i;

endmodule
